seq_handler_core: RTL and testbench
===================================

# seq_handler_core

Eight-channel programmable bit-sequence generator driven by the command-bus interface used by the USB-CDC command dispatcher. A 13-byte configuration command (type 0xF0) sets one channel's enable, bit-rate divider, sequence length and up to 64 pattern bits. Each enabled channel then replays its pattern LSB-first, repeating indefinitely, on its own `seq_pins` bit.

## Interface
- `NUM_CH`, 8: number of sequence channels and `seq_pins` width.
- `MAX_BITS`, 64: maximum pattern length in bits.
- `CMD_SEQ`, 8'hF0: command type this block accepts.
- `clk` in 1: system clock (60 MHz nominal).
- `rst` in 1: reset. Synchronous, active-high; one clock domain.
- `cmd_type` in 8: command code, valid from `cmd_start` to `cmd_done`.
- `cmd_length` in 16: payload byte count of the current command.
- `cmd_data` in 8: payload byte, qualified by `cmd_data_valid`.
- `cmd_data_index` in 16: index of `cmd_data` within the payload.
- `cmd_start` in 1: one-cycle pulse that opens a command.
- `cmd_data_valid` in 1: `cmd_data` and `cmd_data_index` are valid this cycle.
- `cmd_done` in 1: one-cycle pulse that closes a command.
- `cmd_ready` out 1: high when the block can accept a new command.
- `seq_pins` out `NUM_CH`: per-channel sequence outputs.

## Operation
- **Command format.** The payload is 13 bytes:
  - byte 0: channel.
  - byte 1: enable (nonzero means enabled).
  - bytes 2–3: divider, high byte first.
  - byte 4: length; bits [6:0] are used.
  - bytes 5–12: pattern bits 63..0, little-endian (byte 5 holds bits 7:0).
- **Capture.** Bytes are written into a 13-byte shadow buffer by `cmd_data_index` when `cmd_data_valid` is high, `cmd_type == CMD_SEQ` and a command is open. Indices ≥13 are ignored.
- **Command FSM.** States are IDLE → RECV on `cmd_start`, RECV → APPLY on `cmd_done`, APPLY → IDLE after one cycle. `cmd_ready` is high only in IDLE.
- **Apply conditions.** In APPLY the channel registers are updated only if all of the following hold; otherwise the command is discarded with no state change:
  - `cmd_type == CMD_SEQ`;
  - `cmd_length ≥ 13`;
  - all 13 bytes were received;
  - channel < `NUM_CH`.
- **Apply effects.** The new config loads into the addressed channel and that channel restarts at bit 0 with its divider counter cleared. Other channels are not disturbed.
- **Parameter clamping.**
  - divider 0 is treated as 1;
  - length > 64 is clamped to 64;
  - length 0 forces the output low.
- **Channel playback.** Each bit is held for exactly `divider` clocks. The bit index advances 0,1,…,len−1 and then wraps to 0. The output is `pattern[bit_idx]`.
- **Disabled channel.** Output is 0, and the counters are held at 0.
- **Other command types.** Commands that are not `CMD_SEQ` still walk the FSM, so `cmd_ready` drops, but cause no effect.
- **Abandoned commands.** A `cmd_start` while in RECV restarts reception and clears the received-byte flags.

## Timing
- **Reset values.** `seq_pins` = 0, `cmd_ready` = 1, FSM in IDLE. All channels are disabled with divider 1, length 0 and pattern 0.
- **cmd_ready.** Goes low the cycle after `cmd_start` is sampled and returns high 2 cycles after `cmd_done` is sampled.
- **Start-up latency.** The channel registers update on the clock edge that ends APPLY. `seq_pins[ch]` shows pattern bit 0 on the next edge, i.e. 2 cycles after the `cmd_done` edge.
- **Bit boundaries.** They are registered: `seq_pins` changes only on clock edges where the divider counter reaches `divider−1`.
- **Divider counter.** 16-bit. The bit index is 7-bit.
- **Simultaneous events.** If `cmd_data_valid` and `cmd_done` are high in the same cycle, the byte is still captured before APPLY.
- **Reset mid-command.** Reset aborts the command with no partial apply, and all channels return to the reset state.

## Structure
- **Shared package (`seq_pkg`).** Holds `CMD_SEQ`, `PAYLOAD_LEN` = 13, the payload byte offsets (`OFS_CH`, `OFS_EN`, `OFS_DIV_H`, `OFS_DIV_L`, `OFS_LEN`, `OFS_DATA`) and the channel config struct (enable, divider[15:0], length[6:0], pattern[63:0]).
- **Sub-module.** One sub-module `seq_channel`, instantiated `NUM_CH` times. It takes config plus a one-cycle `load` pulse and produces a 1-bit output.
- **Top level.** Holds the command FSM, the shadow buffer, the received-byte mask and the load decode.

## Test plan
- **Basic playback.** CH0, en=1, div=60, len=10, data=0x155 → `seq_pins[0]` toggles 1,0,1,0,… every 60 clocks (1 µs), repeating every 600 clocks; other pins stay 0.
- **Independent channels.** Then CH1 div=30 len=8 data=0xCC and CH2 div=15 len=16 data=0xAAF0 → CH1 emits 0,0,1,1,0,0,1,1 at 30 clocks/bit and CH2 follows 0xAAF0 LSB-first at 15 clocks/bit. CH0 continues without a phase glitch.
- **Disable.** CH0 en=0 → `seq_pins[0]` is 0 within 2 cycles of `cmd_done` and stays 0; CH1 and CH2 are unaffected.
- **Re-enable.** CH0 en=1, div=120, len=4, data=0x0A → restarts at bit 0 and emits 0,1,0,1 at 120 clocks/bit.
- **All channels.** CH3–CH7 with div=60 and patterns 0x3/len2, 0x5/len3, 0x9/len4, 0x15/len5, 0x2A/len6 → each pin follows its pattern. CH3 stays constant 1.
- **Handshake and invalid commands.**
  - `cmd_ready` timing around every command matches the Timing section.
  - An invalid command (type 0xF1, channel 9, or only 12 bytes) leaves all outputs unchanged.
  - Reset asserted mid-payload returns every output to 0 and `cmd_ready` to 1.

Source files
------------

// File: rtl/seq_handler_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared definitions for the sequence-generator block: command
//            code, payload layout, per-channel configuration record, command
//            FSM state encoding and the configuration clamping helper.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

  localparam logic [7:0] CMD_SEQ     = 8'hF0;
  localparam int         PAYLOAD_LEN = 13;

  // Payload byte offsets
  localparam int OFS_CH    = 0;
  localparam int OFS_EN    = 1;
  localparam int OFS_DIV_H = 2;
  localparam int OFS_DIV_L = 3;
  localparam int OFS_LEN   = 4;
  localparam int OFS_DATA  = 5;   // bytes 5..12, little-endian pattern

  typedef struct packed {
    logic        enable;
    logic [15:0] divider;
    logic [6:0]  length;
    logic [63:0] pattern;
  } ch_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_APPLY = 2'd2
  } cmd_state_e;

  localparam ch_cfg_t CFG_RESET = '{enable: 1'b0, divider: 16'd1,
                                    length: 7'd0, pattern: 64'd0};

  // Divider 0 behaves as 1; lengths beyond the pattern store are capped.
  function automatic ch_cfg_t clamp_cfg(input ch_cfg_t raw, input int max_bits);
    ch_cfg_t c;
    c = raw;
    if (c.divider == 16'd0) begin
      c.divider = 16'd1;
    end
    if (int'(c.length) > max_bits) begin
      c.length = 7'(max_bits);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_handler_core_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_handler_core_if
// Purpose  : Command-bus bundle shared with the USB-CDC command dispatcher.
//            master = dispatcher side, slave = command consumer side.
// Signals  : cmd_type, cmd_length, cmd_data, cmd_data_index, cmd_start,
//            cmd_data_valid, cmd_done (dispatcher -> consumer),
//            cmd_ready (consumer -> dispatcher).
// Revision : 1.0 - initial release
// ============================================================================
interface seq_handler_core_if;
  logic [7:0]  cmd_type;
  logic [15:0] cmd_length;
  logic [7:0]  cmd_data;
  logic [15:0] cmd_data_index;
  logic        cmd_start;
  logic        cmd_data_valid;
  logic        cmd_done;
  logic        cmd_ready;

  modport master (
    output cmd_type, cmd_length, cmd_data, cmd_data_index,
           cmd_start, cmd_data_valid, cmd_done,
    input  cmd_ready
  );

  modport slave (
    input  cmd_type, cmd_length, cmd_data, cmd_data_index,
           cmd_start, cmd_data_valid, cmd_done,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/seq_handler_core_channel.sv
`default_nettype none
// ============================================================================
// Module   : seq_channel
// Purpose  : One bit-sequence channel. Holds its configuration, a 16-bit
//            divider counter and a 7-bit bit index, and replays the pattern
//            LSB-first with each bit lasting `divider` clocks.
// Ports    : clk, rst     - clock / synchronous active-high reset
//            load         - one-cycle pulse: take cfg_in and restart at bit 0
//            cfg_in       - already-clamped configuration
//            pin          - registered sequence output
// Revision : 1.0 - initial release
// ============================================================================
module seq_channel
  import seq_pkg::*;
(
  input  wire logic    clk,
  input  wire logic    rst,
  input  wire logic    load,
  input  wire ch_cfg_t cfg_in,
  output logic         pin
);

  ch_cfg_t     cfg_q,     cfg_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [6:0]  bit_idx_q, bit_idx_d;
  logic        pin_q,     pin_d;
  logic        active;

  always_comb begin
    cfg_d     = cfg_q;
    div_cnt_d = div_cnt_q;
    bit_idx_d = bit_idx_q;
    active    = cfg_q.enable && (cfg_q.length != 7'd0);

    // The output is registered from the current index, so a new bit appears
    // one edge after the index moves; every bit therefore still lasts
    // exactly `divider` clocks. Length is capped at 64, so [5:0] suffices.
    pin_d = active ? cfg_q.pattern[bit_idx_q[5:0]] : 1'b0;

    if (load) begin
      cfg_d     = cfg_in;
      div_cnt_d = '0;
      bit_idx_d = '0;
    end else if (!active) begin
      div_cnt_d = '0;
      bit_idx_d = '0;
    end else if (div_cnt_q == cfg_q.divider - 16'd1) begin
      div_cnt_d = '0;
      bit_idx_d = (bit_idx_q == cfg_q.length - 7'd1) ? 7'd0 : bit_idx_q + 7'd1;
    end else begin
      div_cnt_d = div_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q     <= CFG_RESET;
      div_cnt_q <= '0;
      bit_idx_q <= '0;
      pin_q     <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      div_cnt_q <= div_cnt_d;
      bit_idx_q <= bit_idx_d;
      pin_q     <= pin_d;
    end
  end

  assign pin = pin_q;

endmodule
`default_nettype wire

// File: rtl/seq_handler_core.sv
`default_nettype none
// ============================================================================
// Module   : seq_handler_core
// Purpose  : Eight-channel programmable bit-sequence generator. Receives
//            13-byte configuration commands over the command bus, validates
//            them and loads the addressed channel.
// Ports    : clk, rst     - clock / synchronous active-high reset
//            bus          - command bus (slave side), cmd_ready driven here
//            seq_pins     - one sequence output per channel
// Params   : NUM_CH (channels), MAX_BITS (pattern length cap, <= 64),
//            CMD_SEQ (accepted command code)
// Revision : 1.0 - initial release
// ============================================================================
module seq_handler_core #(
  parameter int         NUM_CH   = 8,
  parameter int         MAX_BITS = 64,
  parameter logic [7:0] CMD_SEQ  = seq_pkg::CMD_SEQ
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  seq_handler_core_if.slave          bus,
  output logic [NUM_CH-1:0]          seq_pins
);

  import seq_pkg::*;

  cmd_state_e             state_q,   state_d;
  logic [7:0]             pbuf_q [PAYLOAD_LEN];
  logic [7:0]             pbuf_d [PAYLOAD_LEN];
  logic [PAYLOAD_LEN-1:0] rcvd_q,    rcvd_d;
  logic                   type_ok_q, type_ok_d;
  logic                   len_ok_q,  len_ok_d;

  logic                   cap_en;
  logic                   apply_ok;
  ch_cfg_t                raw_cfg;
  ch_cfg_t                new_cfg;
  logic [NUM_CH-1:0]      load;

  assign cap_en = (state_q == ST_RECV) && bus.cmd_data_valid &&
                  (bus.cmd_type == CMD_SEQ) &&
                  (bus.cmd_data_index < 16'(PAYLOAD_LEN));

  // --------------------------------------------------------------------------
  // Command FSM, shadow buffer and received-byte mask
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pbuf_d    = pbuf_q;
    rcvd_d    = rcvd_q;
    type_ok_d = type_ok_q;
    len_ok_d  = len_ok_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_start) begin
          state_d = ST_RECV;
          rcvd_d  = '0;
        end
      end

      ST_RECV: begin
        // cmd_type/cmd_length are only guaranteed up to cmd_done, so their
        // verdicts are tracked here and the done-cycle value is kept for APPLY.
        type_ok_d = (bus.cmd_type == CMD_SEQ);
        len_ok_d  = (bus.cmd_length >= 16'(PAYLOAD_LEN));
        if (bus.cmd_start) begin
          rcvd_d = '0;                 // abandoned command: start over
        end else if (bus.cmd_done) begin
          state_d = ST_APPLY;
        end
        // A byte arriving with cmd_done is still captured before APPLY.
        for (int i = 0; i < PAYLOAD_LEN; i++) begin
          if (cap_en && (bus.cmd_data_index == 16'(i))) begin
            pbuf_d[i] = bus.cmd_data;
            rcvd_d[i] = 1'b1;
          end
        end
      end

      ST_APPLY: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rcvd_q    <= '0;
      type_ok_q <= 1'b0;
      len_ok_q  <= 1'b0;
      for (int i = 0; i < PAYLOAD_LEN; i++) begin
        pbuf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rcvd_q    <= rcvd_d;
      type_ok_q <= type_ok_d;
      len_ok_q  <= len_ok_d;
      pbuf_q    <= pbuf_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);

  // --------------------------------------------------------------------------
  // Configuration decode and load
  // --------------------------------------------------------------------------
  always_comb begin
    raw_cfg         = CFG_RESET;
    raw_cfg.enable  = |pbuf_q[OFS_EN];
    raw_cfg.divider = {pbuf_q[OFS_DIV_H], pbuf_q[OFS_DIV_L]};
    raw_cfg.length  = pbuf_q[OFS_LEN][6:0];
    for (int i = 0; i < 8; i++) begin
      raw_cfg.pattern[8*i +: 8] = pbuf_q[OFS_DATA + i];
    end
  end

  assign new_cfg  = clamp_cfg(raw_cfg, MAX_BITS);

  assign apply_ok = (state_q == ST_APPLY) && type_ok_q && len_ok_q &&
                    (&rcvd_q) && (int'({24'd0, pbuf_q[OFS_CH]}) < NUM_CH);

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign load[g] = apply_ok && (pbuf_q[OFS_CH] == 8'(g));

      seq_channel u_channel (
        .clk    (clk),
        .rst    (rst),
        .load   (load[g]),
        .cfg_in (new_cfg),
        .pin    (seq_pins[g])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_seq_handler_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_handler_core
// Purpose  : Self-checking bench for seq_handler_core. A time-based model
//            predicts every pin as pattern[((t - start) / div) % len] and
//            cmd_ready from command windows; checked on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_handler_core;

  localparam int NCH   = 8;
  localparam int NEVER = 32'h7fff_ffff;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] seq_pins;

  seq_handler_core_if bus();

  seq_handler_core #(.NUM_CH(NCH), .MAX_BITS(64), .CMD_SEQ(8'hF0)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .seq_pins (seq_pins)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- model state (current and previous config per channel)
  bit          c_en [NCH];  int c_div [NCH]; int c_len [NCH];
  logic [63:0] c_pat [NCH]; int c_st  [NCH];
  bit          p_en [NCH];  int p_div [NCH]; int p_len [NCH];
  logic [63:0] p_pat [NCH]; int p_st  [NCH];
  int          rdy_low_from  = 0;
  int          rdy_high_from = 0;
  int          last_st = 0;
  bit          chk_en  = 1'b0;

  function automatic bit eval_pin(bit en, int dv, int ln, logic [63:0] pat, int st, int n);
    if (!en || ln == 0) return 1'b0;
    return pat[((n - st) / dv) % ln];
  endfunction

  function automatic logic [NCH-1:0] exp_pins(int n);
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) begin
      r[c] = (n < c_st[c]) ? eval_pin(p_en[c], p_div[c], p_len[c], p_pat[c], p_st[c], n)
                           : eval_pin(c_en[c], c_div[c], c_len[c], c_pat[c], c_st[c], n);
    end
    return r;
  endfunction

  function automatic int clampl(logic [7:0] ln);
    int l;
    l = int'(ln[6:0]);
    if (l > 64) l = 64;
    return l;
  endfunction

  task automatic model_set(int c, bit en, int dv, int ln, logic [63:0] pat, int st);
    p_en[c] = c_en[c]; p_div[c] = c_div[c]; p_len[c] = c_len[c];
    p_pat[c] = c_pat[c]; p_st[c] = c_st[c];
    c_en[c] = en; c_div[c] = dv; c_len[c] = ln; c_pat[c] = pat; c_st[c] = st;
  endtask

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cyc=%0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- per-cycle compare
  always @(negedge clk) begin : p_cmp
    logic [NCH-1:0] e;
    bit             er;
    if (chk_en) begin
      e  = exp_pins(cyc);
      er = !(cyc >= rdy_low_from && cyc < rdy_high_from);
      total++;
      if (seq_pins !== e) begin
        bad++;
        $display("FAIL seq_pins: got=%b expected=%b (cyc=%0d)", seq_pins, e, cyc);
      end
      total++;
      if (bus.cmd_ready !== er) begin
        bad++;
        $display("FAIL cmd_ready: got=%b expected=%b (cyc=%0d)", bus.cmd_ready, er, cyc);
      end
    end
  end

  // ---------------- drivers
  task automatic wait_to(int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic open_cmd(logic [7:0] typ, int plen);
    @(posedge clk); #1;
    bus.cmd_type   = typ;
    bus.cmd_length = 16'(plen);
    bus.cmd_start  = 1'b1;
    if (!(cyc >= rdy_low_from && cyc < rdy_high_from)) rdy_low_from = cyc + 1;
    rdy_high_from = NEVER;
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
  endtask

  task automatic close_cmd(bit ok, logic [7:0] ch, logic [7:0] en, logic [15:0] dv,
                           logic [7:0] ln, logic [63:0] pat);
    bus.cmd_done  = 1'b1;
    rdy_high_from = cyc + 2;
    last_st       = cyc + 3;
    if (ok) model_set(int'(ch), en != 8'd0, (dv == 16'd0) ? 1 : int'(dv), clampl(ln), pat, cyc + 3);
  endtask

  task automatic send_cmd(logic [7:0] typ, int plen, logic [7:0] ch, logic [7:0] en,
                          logic [15:0] dv, logic [7:0] ln, logic [63:0] pat,
                          int skip, bit merge, bit junk, int maxgap);
    logic [7:0] b [13];
    int         last;
    bit         ok;
    b[0] = ch; b[1] = en; b[2] = dv[15:8]; b[3] = dv[7:0]; b[4] = ln;
    for (int i = 0; i < 8; i++) b[5 + i] = pat[8*i +: 8];
    last = (skip == 12) ? 11 : 12;
    ok   = (typ == 8'hF0) && (plen >= 13) && (skip < 0) && (ch < 8'd8);
    open_cmd(typ, plen);
    for (int i = 0; i < 13; i++) begin
      if (i != skip) begin
        repeat ($urandom_range(maxgap, 0)) begin @(posedge clk); #1; end
        bus.cmd_data_valid = 1'b1;
        bus.cmd_data_index = 16'(i);
        bus.cmd_data       = b[i];
        if (merge && i == last) close_cmd(ok, ch, en, dv, ln, pat);
        @(posedge clk); #1;
        bus.cmd_data_valid = 1'b0;
        bus.cmd_done       = 1'b0;
      end
    end
    if (!merge) begin
      if (junk) begin
        for (int j = 13; j < 16; j++) begin
          bus.cmd_data_valid = 1'b1;
          bus.cmd_data_index = 16'(j);
          bus.cmd_data       = 8'hFF;
          @(posedge clk); #1;
          bus.cmd_data_valid = 1'b0;
        end
      end
      close_cmd(ok, ch, en, dv, ln, pat);
      @(posedge clk); #1;
      bus.cmd_done = 1'b0;
    end
  endtask

  // Opens a command and sends some bytes but never closes it.
  task automatic partial_cmd(int nbytes);
    open_cmd(8'hF0, 13);
    for (int i = 0; i < nbytes; i++) begin
      bus.cmd_data_valid = 1'b1;
      bus.cmd_data_index = 16'(i);
      bus.cmd_data       = 8'($urandom_range(255, 0));
      @(posedge clk); #1;
      bus.cmd_data_valid = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence
  initial begin
    logic [NCH-1:0] mp;
    int s1, s2;
    for (int c = 0; c < NCH; c++) begin
      c_en[c] = 0; c_div[c] = 1; c_len[c] = 0; c_pat[c] = '0; c_st[c] = 0;
      p_en[c] = 0; p_div[c] = 1; p_len[c] = 0; p_pat[c] = '0; p_st[c] = 0;
    end
    rst = 1'b1;
    bus.cmd_type = '0; bus.cmd_length = '0; bus.cmd_data = '0; bus.cmd_data_index = '0;
    bus.cmd_start = 1'b0; bus.cmd_data_valid = 1'b0; bus.cmd_done = 1'b0;
    idle(4);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_pins", 64'(seq_pins), 64'd0);
    chk("reset_ready", 64'(bus.cmd_ready), 64'd1);

    // Basic playback: CH0 0x155 len10 div60
    send_cmd(8'hF0, 13, 8'd0, 8'd1, 16'd60, 8'd10, 64'h155, -1, 1'b0, 1'b0, 0);
    s1 = last_st;
    wait_to(s1 - 1);  chk("ch0_latency",   64'(seq_pins[0]), 64'd0);
    wait_to(s1);      chk("ch0_bit0",      64'(seq_pins[0]), 64'd1);
                      chk("others_zero",   64'(seq_pins[7:1]), 64'd0);
    wait_to(s1 + 59); chk("ch0_bit0_hold", 64'(seq_pins[0]), 64'd1);
    wait_to(s1 + 60); chk("ch0_bit1",      64'(seq_pins[0]), 64'd0);
    mp = exp_pins(s1 + 125);
    chk("model_ch0_bit2", 64'(mp[0]), 64'd1);
    wait_to(s1 + 540); chk("ch0_bit9",     64'(seq_pins[0]), 64'd0);
    wait_to(s1 + 600); chk("ch0_wrap",     64'(seq_pins[0]), 64'd1);

    // Independent channels
    send_cmd(8'hF0, 13, 8'd1, 8'd1, 16'd30, 8'd8, 64'hCC, -1, 1'b0, 1'b0, 0);
    s1 = last_st;
    send_cmd(8'hF0, 13, 8'd2, 8'd1, 16'd15, 8'd16, 64'hAAF0, -1, 1'b1, 1'b0, 0);
    s2 = last_st;
    wait_to(s1 + 30); chk("ch1_bit1", 64'(seq_pins[1]), 64'd0);
    wait_to(s1 + 60); chk("ch1_bit2", 64'(seq_pins[1]), 64'd1);
    wait_to(s2 + 60); chk("ch2_bit4", 64'(seq_pins[2]), 64'd1);
    mp = exp_pins(s2 + 15 * 13);
    chk("model_ch2_bit13", 64'(mp[2]), 64'd1);
    idle(700);

    // Disable CH0
    send_cmd(8'hF0, 13, 8'd0, 8'd0, 16'd60, 8'd10, 64'h155, -1, 1'b0, 1'b0, 0);
    wait_to(last_st); chk("ch0_disabled", 64'(seq_pins[0]), 64'd0);
    idle(300);

    // Re-enable CH0: 0x0A len4 div120 -> 0,1,0,1
    send_cmd(8'hF0, 13, 8'd0, 8'd1, 16'd120, 8'd4, 64'h0A, -1, 1'b0, 1'b0, 0);
    s1 = last_st;
    wait_to(s1);       chk("ch0_re_bit0", 64'(seq_pins[0]), 64'd0);
    wait_to(s1 + 120); chk("ch0_re_bit1", 64'(seq_pins[0]), 64'd1);
    wait_to(s1 + 240); chk("ch0_re_bit2", 64'(seq_pins[0]), 64'd0);

    // All channels
    send_cmd(8'hF0, 13, 8'd3, 8'd1, 16'd60, 8'd2, 64'h3,  -1, 1'b0, 1'b1, 0);
    send_cmd(8'hF0, 13, 8'd4, 8'd1, 16'd60, 8'd3, 64'h5,  -1, 1'b0, 1'b0, 0);
    send_cmd(8'hF0, 13, 8'd5, 8'd1, 16'd60, 8'd4, 64'h9,  -1, 1'b1, 1'b0, 0);
    send_cmd(8'hF0, 13, 8'd6, 8'd1, 16'd60, 8'd5, 64'h15, -1, 1'b0, 1'b0, 0);
    send_cmd(8'hF0, 13, 8'd7, 8'd1, 16'd60, 8'd6, 64'h2A, -1, 1'b0, 1'b0, 0);
    wait_to(cyc + 10);  chk("ch3_const_a", 64'(seq_pins[3]), 64'd1);
    wait_to(cyc + 100); chk("ch3_const_b", 64'(seq_pins[3]), 64'd1);
    idle(400);

    // Invalid commands: wrong type, channel 9, 12 bytes, short length
    send_cmd(8'hF1, 13, 8'd1, 8'd1, 16'd3, 8'd5, 64'h1F, -1, 1'b0, 1'b0, 0);
    idle(100);
    send_cmd(8'hF0, 13, 8'd9, 8'd1, 16'd3, 8'd5, 64'h1F, -1, 1'b0, 1'b0, 0);
    idle(100);
    send_cmd(8'hF0, 13, 8'd1, 8'd1, 16'd3, 8'd5, 64'h1F, 7, 1'b0, 1'b0, 0);
    idle(100);
    send_cmd(8'hF0, 12, 8'd1, 8'd1, 16'd3, 8'd5, 64'h1F, -1, 1'b0, 1'b0, 0);
    idle(100);

    // Abandoned command followed by a complete one
    partial_cmd(6);
    send_cmd(8'hF0, 13, 8'd2, 8'd1, 16'd2, 8'd3, 64'h6, -1, 1'b0, 1'b0, 0);
    idle(100);

    // Reset mid-payload
    partial_cmd(5);
    rst = 1'b1;
    for (int c = 0; c < NCH; c++) model_set(c, 1'b0, 1, 0, 64'd0, cyc + 1);
    rdy_high_from = cyc + 1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_pins",  64'(seq_pins), 64'd0);
    chk("midrst_ready", 64'(bus.cmd_ready), 64'd1);
    idle(20);

    // Randomized commands
    for (int r = 0; r < 40; r++) begin
      logic [7:0] typ, ch, en, ln;
      int         plen, skip;
      if ($urandom_range(7, 0) == 0) partial_cmd($urandom_range(10, 0));
      typ  = ($urandom_range(9, 0) == 0) ? 8'hF1 : 8'hF0;
      plen = ($urandom_range(9, 0) == 0) ? 12 : 13 + $urandom_range(3, 0);
      ch   = ($urandom_range(15, 0) == 0) ? 8'($urandom_range(12, 8)) : 8'($urandom_range(7, 0));
      en   = 8'($urandom_range(3, 0));
      ln   = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 0)) : 8'($urandom_range(20, 0));
      skip = ($urandom_range(19, 0) == 0) ? $urandom_range(12, 0) : -1;
      send_cmd(typ, plen, ch, en, 16'($urandom_range(6, 0)), ln, {$urandom, $urandom},
               skip, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 2);
      idle($urandom_range(150, 0));
    end
    idle(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
